// File: rtl/muldiv_seq.sv
// Iterative MIPS multiply/divide unit owning the HI/LO pair.
// Radix-2 shift-add multiply and restoring divide on magnitudes, with sign fix-up at the end.
module muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       hilo_we,
  input  logic [WIDTH-1:0] hilo_wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(ITER) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dbz_q, dbz_d;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum, rem_sh, trial;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  // op[0]=0 selects signed operands; 0x80000000 negates to itself and is read as 2^31.
  assign abs_a = (!op[0] && a[WIDTH-1]) ? -a : a;
  assign abs_b = (!op[0] && b[WIDTH-1]) ? -b : b;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
  assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
  assign trial    = rem_sh - {1'b0, opnd_q};

  assign prod_fix = neg_res_q ? -acc_q : acc_q;
  assign quot_fix = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    opnd_d    = opnd_q;
    a_d       = a_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dbz_d     = dbz_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          op_d      = op;
          a_d       = a;
          cnt_d     = '0;
          dbz_d     = 1'b0;
          neg_res_d = !op[0] && (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_rem_d = !op[0] && a[WIDTH-1];
          // Divide keeps the divisor in opnd and the dividend in the low accumulator half;
          // multiply keeps the multiplicand in opnd and the multiplier in the low half.
          if (op[1]) begin
            opnd_d = abs_b;
            acc_d  = {{WIDTH{1'b0}}, abs_a};
          end else begin
            opnd_d = abs_a;
            acc_d  = {{WIDTH{1'b0}}, abs_b};
          end
          state_d = CALC;
        end else begin
          state_d = IDLE;
          if (hilo_we[1]) hi_d = hilo_wdata;
          if (hilo_we[0]) lo_d = hilo_wdata;
        end
      end
      CALC: begin
        if (op_q[1]) begin
          if (!trial[WIDTH]) acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else               acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
          if (acc_q[0]) acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          else          acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(ITER - 1)) state_d = FIX;
      end
      FIX: begin
        if (op_q[1]) begin
          if (opnd_q == '0) begin
            hi_d  = a_q;
            lo_d  = '1;
            dbz_d = 1'b1;
          end else begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= '0;
      opnd_q    <= '0;
      a_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      opnd_q    <= opnd_d;
      a_q       <= a_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy        = (state_q == CALC) || (state_q == FIX);
  assign done        = (state_q == DONE);
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Iterative multiply/divide unit with its own sequencer. It executes MULT, MULTU, DIV and DIVU for the MIPS core and owns the HI/LO register pair. One radix-2 step per cycle: shift-add for multiply, restoring for divide. Operand signedness is selected per op in the same signed/unsigned style as the immediate extender. The decode stage stalls on busy and reads HI/LO for MFHI/MFLO. MTHI/MTLO write through a separate port.

Parameters:
WIDTH, 32, operand/HI/LO width
ITER, 32, CALC iterations (equals WIDTH)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled when busy=0
op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU (op[0]=0 means signed)
a  in  32  rs operand (multiplicand / dividend)
b  in  32  rt operand (multiplier / divisor)
hilo_we  in  2  bit1 writes HI, bit0 writes LO (MTHI/MTLO)
hilo_wdata  in  32  MTHI/MTLO data
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse
div_by_zero  out  1  last DIV/DIVU had b=0
hi  out  32  HI register
lo  out  32  LO register

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous and active-low. While rst_n=0: state=IDLE, hi=lo=0, busy=0, done=0, div_by_zero=0, internal registers cleared. Reset mid-operation aborts it; no partial HI/LO update.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE or DONE with start=1:
  - latch op;
  - signed op: latch |a|, |b| and the result-sign bits;
  - unsigned op: latch a, b as-is;
  - clear the iteration counter; clear div_by_zero; go to CALC.
- IDLE or DONE with start=0: go to IDLE (DONE lasts exactly one cycle).
- CALC: one step per cycle for ITER cycles, then go to FIX.
  - Multiply: 64-bit product accumulator, conditional add of the multiplicand, right shift.
  - Divide: 64-bit remainder/quotient register, left shift, trial subtract of the divisor, restore when negative, quotient bit = no-borrow.
- FIX: apply sign correction and write HI/LO, then go to DONE.
  - MULT: 64-bit two's-complement negate if a[31]^b[31]. HI = upper 32, LO = lower 32.
  - DIV: quotient negated if a[31]^b[31]; remainder takes the sign of a. LO = quotient, HI = remainder.
  - MULTU/DIVU: no correction.
  - Divide with b=0, either signedness: HI=a, LO=32'hFFFFFFFF, div_by_zero=1.
  - 0x80000000 magnitude is handled as unsigned 2^31. DIV 0x80000000/0xFFFFFFFF gives LO=0x80000000, HI=0 (wraps, no trap).
- DONE: done=1 and busy=0 for this single cycle.
- Timing: start sampled at edge 0; busy=1 for cycles 1..33 (CALC 1..32, FIX 33); HI/LO updated at edge 34; done=1 in cycle 34.
- Back-to-back: start may be asserted in the DONE cycle and is accepted there.
- start while busy=1 is ignored; no queuing.
- hilo_we:
  - honoured only when busy=0 and start=0; HI/LO update at the next edge.
  - ignored while busy=1, and when start=1 in the same cycle (start wins).
  - both bits set: both registers written with hilo_wdata.
- hi/lo hold their value between operations; reads are combinational from the registers.
- div_by_zero holds until the next accepted start.

Test Plan:
- MULT a=0xFFFFFFFE, b=3 -> busy cycles 1-33, done in cycle 34; HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Then MULT 0 x 0x7FFFFFFF, started in the DONE cycle -> accepted; HI=LO=0.
- DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=7, b=2 -> LO=3, HI=1. DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIV a=0x12345678, b=0 -> HI=0x12345678, LO=0xFFFFFFFF, div_by_zero=1. A following MULTU 2x3 clears the flag -> LO=6, HI=0.
- During a DIV, pulse start at cycle 5 with new operands and hilo_we=2'b11 at cycle 10 -> both ignored; original result only. In idle, hilo_we=2'b01 with wdata=0xCAFEBABE -> LO=0xCAFEBABE, HI unchanged. start and hilo_we together -> no HI/LO write.
- Drop rst_n at CALC cycle 10 -> busy, done and div_by_zero drop to 0 and hi/lo to 0 immediately, without waiting for a clock edge. After release, MULTU 5x5 -> LO=25 at cycle 34.
